// File: rtl/piradip_lzc_normalize_prep_if.sv
// Stream link used on both sides of the leading-zero-count stage:
// data word, valid, packet delimiter and ready.
interface piradip_lzc_normalize_prep_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] tdata;
   logic             tvalid;
   logic             tlast;
   logic             tready;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/piradip_lzc_normalize_prep.sv
// Two-stage leading-zero counter. S1 registers the raw word; S2 registers
// {lzc, word}, which is the packed form the left shifter consumes, so
// chaining the two yields a normalized word plus its shift count.
// data_out is driven straight from S2 registers.
module piradip_lzc_normalize_prep #(
   parameter int DATA_WIDTH  = 32,
   parameter int SHIFT_WIDTH = $clog2(DATA_WIDTH) + 1
) (
   input logic                          aclk,
   input logic                          aresetn,
   piradip_lzc_normalize_prep_if.slave  data_in,
   piradip_lzc_normalize_prep_if.master data_out
);

   logic                              s1_valid;
   logic                              s1_last;
   logic [DATA_WIDTH-1:0]             s1_data;
   logic                              s2_valid;
   logic                              s2_last;
   logic [DATA_WIDTH+SHIFT_WIDTH-1:0] s2_data;
   logic [SHIFT_WIDTH-1:0]            lzc;
   logic                              adv1;
   logic                              adv2;

   // S2 moves when it is empty or being drained; S1 moves when empty or S2 moves.
   assign adv2 = ~s2_valid | data_out.tready;
   assign adv1 = ~s1_valid | adv2;
   assign data_in.tready = aresetn & adv1;

   assign data_out.tvalid = s2_valid;
   assign data_out.tlast  = s2_last;
   assign data_out.tdata  = s2_data;

   // Priority encode the highest set bit; all-zero input counts as DATA_WIDTH.
   always_comb begin
      lzc = SHIFT_WIDTH'(DATA_WIDTH);
      for (int i = 0; i < DATA_WIDTH; i++) begin
         if (s1_data[i]) lzc = SHIFT_WIDTH'(DATA_WIDTH - 1 - i);
      end
   end

   // Stage 1: capture the raw input word on an accepted beat.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
         s1_data  <= '0;
      end else if (adv1) begin
         s1_valid <= data_in.tvalid;
         if (data_in.tvalid && data_in.tready) begin
            s1_last <= data_in.tlast;
            s1_data <= data_in.tdata;
         end
      end
   end

   // Stage 2: capture {lzc, word}; holds while the output is stalled.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         s2_valid <= 1'b0;
         s2_last  <= 1'b0;
         s2_data  <= '0;
      end else if (adv2) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_last <= s1_last;
            s2_data <= {lzc, s1_data};
         end
      end
   end

endmodule

// File: tb/tb_piradip_lzc_normalize_prep.sv
// Bench for the leading-zero-count stage: directed vector table, backpressure,
// packet, reset and random streams against an independent reference model.
module tb_piradip_lzc_normalize_prep;

   localparam int DW = 32;
   localparam int SW = 6;

   logic aclk = 1'b0;
   logic aresetn;

   piradip_lzc_normalize_prep_if #(.WIDTH(DW))      din();
   piradip_lzc_normalize_prep_if #(.WIDTH(DW + SW)) dout();

   piradip_lzc_normalize_prep #(.DATA_WIDTH(DW), .SHIFT_WIDTH(SW)) dut (
      .aclk     (aclk),
      .aresetn  (aresetn),
      .data_in  (din),
      .data_out (dout)
   );

   always #5 aclk = ~aclk;

   int n_checks = 0;
   int n_pass   = 0;
   int n_out    = 0;
   int n_last   = 0;
   logic [DW+SW:0] sb_q[$];
   logic [DW+SW:0] sb_e;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [SW-1:0] ref_lzc(input logic [DW-1:0] d);
      int n = 0;
      while (n < DW && d[DW-1-n] == 1'b0) n++;
      return SW'(n);
   endfunction

   // Scoreboard: inputs and outputs are stable at the falling edge.
   always @(negedge aclk) begin
      if (!aresetn) begin
         sb_q.delete();
      end else begin
         if (dout.tvalid && dout.tready) begin
            n_out++;
            if (dout.tlast) n_last++;
            if (sb_q.size() == 0) begin
               check("sb_underflow", 64'd1, 64'd0);
            end else begin
               sb_e = sb_q.pop_front();
               check("sb_beat", 64'({dout.tlast, dout.tdata}), 64'(sb_e));
            end
         end
         if (din.tvalid && din.tready)
            sb_q.push_back({din.tlast, ref_lzc(din.tdata), din.tdata});
      end
   end

   typedef struct {
      logic [DW-1:0] din;
      logic [SW-1:0] lzc;
      logic [DW-1:0] shifted;
   } vec_t;

   vec_t vecs[8];

   task automatic run_stream(input int n, input bit pkt, input int vprob, input int rprob);
      int  sent = 0;
      int  cyc  = 0;
      bit  acc  = 1'b0;
      while (sent < n && cyc < 20 * n + 100) begin
         @(posedge aclk); #1;
         cyc++;
         if (!din.tvalid || acc) begin
            if ($urandom_range(0, 99) < vprob) begin
               din.tvalid = 1'b1;
               din.tdata  = pkt ? (32'h0000_0100 << (sent * 3)) | DW'(sent)
                                : ($urandom() >> $urandom_range(0, 32));
               din.tlast  = pkt ? (sent == n - 1) : 1'($urandom_range(0, 1));
            end else begin
               din.tvalid = 1'b0;
            end
         end
         dout.tready = ($urandom_range(0, 99) < rprob);
         @(negedge aclk);
         acc = din.tvalid && din.tready;
         if (acc) sent++;
      end
      @(posedge aclk); #1;
      din.tvalid = 1'b0;
      din.tlast  = 1'b0;
      check("stream_done", 64'(sent), 64'(n));
   endtask

   task automatic drain();
      dout.tready = 1'b1;
      repeat (6) @(posedge aclk);
      #1;
      check("sb_empty", 64'(sb_q.size()), 64'd0);
   endtask

   initial begin
      logic [DW-1:0] sh;
      logic [DW+SW-1:0] exp_bp[4];

      vecs[0] = '{32'h8000_0000, 6'd0,  32'h8000_0000};
      vecs[1] = '{32'h0001_0000, 6'd15, 32'h8000_0000};
      vecs[2] = '{32'h0000_0001, 6'd31, 32'h8000_0000};
      vecs[3] = '{32'h0000_0000, 6'd32, 32'h0000_0000};
      vecs[4] = '{32'h0001_2345, 6'd15, 32'h91A2_8000};
      vecs[5] = '{32'h00F0_0000, 6'd8,  32'hF000_0000};
      vecs[6] = '{32'h0000_0003, 6'd30, 32'hC000_0000};
      vecs[7] = '{32'hFFFF_FFFF, 6'd0,  32'hFFFF_FFFF};

      aresetn     = 1'b0;
      din.tvalid  = 1'b0;
      din.tdata   = '0;
      din.tlast   = 1'b0;
      dout.tready = 1'b1;
      repeat (2) @(posedge aclk);
      #1;
      check("rst_in_ready", 64'(din.tready), 64'd0);
      check("rst_out_valid", 64'(dout.tvalid), 64'd0);
      check("rst_out_data", 64'(dout.tdata), 64'd0);
      check("rst_out_last", 64'(dout.tlast), 64'd0);
      aresetn = 1'b1;
      #1;
      check("post_rst_ready", 64'(din.tready), 64'd1);

      // Back-to-back vectors, each checked exactly two edges after acceptance.
      for (int i = 0; i < 10; i++) begin
         @(posedge aclk); #1;
         if (i >= 2) begin
            check("vec_valid", 64'(dout.tvalid), 64'd1);
            check("vec_data", 64'(dout.tdata), 64'({vecs[i-2].lzc, vecs[i-2].din}));
            sh = dout.tdata[DW-1:0] << dout.tdata[DW +: SW];
            check("vec_shifted", 64'(sh), 64'(vecs[i-2].shifted));
         end
         if (i < 8) begin
            din.tvalid = 1'b1;
            din.tdata  = vecs[i].din;
         end else begin
            din.tvalid = 1'b0;
         end
      end
      @(posedge aclk); #1;
      check("vec_idle", 64'(dout.tvalid), 64'd0);

      // Backpressure: A and B absorbed, C refused until the output drains.
      exp_bp[0] = {6'd16, 32'h0000_8000};
      exp_bp[1] = {6'd2,  32'h2000_0000};
      exp_bp[2] = {6'd25, 32'h0000_0040};
      exp_bp[3] = {6'd4,  32'h0800_0000};
      dout.tready = 1'b0;
      din.tvalid  = 1'b1;
      din.tdata   = exp_bp[0][DW-1:0];
      #1;
      check("bp_rdy_a", 64'(din.tready), 64'd1);
      @(posedge aclk); #1;
      din.tdata = exp_bp[1][DW-1:0];
      #1;
      check("bp_rdy_b", 64'(din.tready), 64'd1);
      @(posedge aclk); #1;
      din.tdata = exp_bp[2][DW-1:0];
      #1;
      check("bp_rdy_c", 64'(din.tready), 64'd0);
      check("bp_out_a", 64'(dout.tdata), 64'(exp_bp[0]));
      repeat (2) @(posedge aclk);
      #1;
      check("bp_still_full", 64'(din.tready), 64'd0);
      check("bp_hold_a", 64'(dout.tdata), 64'(exp_bp[0]));
      dout.tready = 1'b1;
      #1;
      check("bp_resume", 64'(din.tready), 64'd1);
      @(posedge aclk); #1;
      din.tdata = exp_bp[3][DW-1:0];
      check("bp_out_b", 64'(dout.tdata), 64'(exp_bp[1]));
      @(posedge aclk); #1;
      din.tvalid = 1'b0;
      check("bp_out_c", 64'(dout.tdata), 64'(exp_bp[2]));
      @(posedge aclk); #1;
      check("bp_out_d", 64'(dout.tdata), 64'(exp_bp[3]));
      check("bp_out_d_valid", 64'(dout.tvalid), 64'd1);
      @(posedge aclk); #1;
      check("bp_empty", 64'(dout.tvalid), 64'd0);

      // 5-beat packet under random stalls: exactly one tlast, on beat 5.
      n_last = 0;
      run_stream(5, 1'b1, 60, 50);
      drain();
      check("pkt_last_count", 64'(n_last), 64'd1);

      // Reset with two beats in flight.
      dout.tready = 1'b1;
      @(posedge aclk); #1;
      din.tvalid = 1'b1;
      din.tdata  = 32'h0000_0F00;
      din.tlast  = 1'b0;
      @(posedge aclk); #1;
      din.tdata  = 32'h0000_00F0;
      din.tlast  = 1'b1;
      @(posedge aclk); #1;
      din.tvalid = 1'b0;
      din.tlast  = 1'b0;
      aresetn    = 1'b0;
      #1;
      check("mid_rst_ready", 64'(din.tready), 64'd0);
      @(posedge aclk); #1;
      aresetn = 1'b1;
      check("mid_rst_valid", 64'(dout.tvalid), 64'd0);
      check("mid_rst_data", 64'(dout.tdata), 64'd0);
      check("mid_rst_last", 64'(dout.tlast), 64'd0);
      #1;
      check("mid_rst_rdy_after", 64'(din.tready), 64'd1);
      din.tvalid = 1'b1;
      din.tdata  = 32'h00F0_0000;
      @(posedge aclk); #1;
      din.tvalid = 1'b0;
      check("mid_rst_lat1", 64'(dout.tvalid), 64'd0);
      @(posedge aclk); #1;
      check("mid_rst_new_valid", 64'(dout.tvalid), 64'd1);
      check("mid_rst_new_data", 64'(dout.tdata), 64'({6'd8, 32'h00F0_0000}));
      drain();

      // Long random stream: no loss, duplication or reordering.
      n_out = 0;
      run_stream(1000, 1'b0, 70, 60);
      drain();
      check("rand_out_count", 64'(n_out), 64'd1000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
